// File: rtl/img_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_rom_pkg
// Description : Shared constants, FSM state type and latency helper for the
//               image ROM reader.
// Revision    : 1.0 - initial release
// ============================================================================
package img_rom_pkg;

   // Width of the internal x/y pixel counters
   localparam int COORD_W = 12;

   // Pixel value shown outside the picture window or before frame lock
   localparam logic [23:0] BG_COLOR_DEFAULT = 24'h000000;

   typedef enum logic {
      WAIT_VS = 1'b0,
      ACTIVE  = 1'b1
   } state_e;

   // Total input-to-output latency: address register + ROM + output register
   function automatic int lat(input int rd_latency);
      return rd_latency + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/img_rom_reader_sig_delay.sv
`default_nettype none
// ============================================================================
// Module      : sig_delay
// Description : WIDTH x DEPTH shift register, asynchronously cleared to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sig_delay #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift the input one stage per clock; reset empties every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/img_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : img_rom_reader
// Description : Fetches an IMG_W x IMG_H picture from a synchronous ROM in
//               step with the video timing stream and emits RGB pixels
//               aligned with the delayed vs/hs/de.
// Revision    : 1.0 - initial release
// ============================================================================
module img_rom_reader
   import img_rom_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 24,
   parameter int                    IMG_W      = 256,
   parameter int                    IMG_H      = 256,
   parameter int                    H_OFFSET   = 0,
   parameter int                    V_OFFSET   = 0,
   parameter int                    RD_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] BG_COLOR   = DATA_WIDTH'(BG_COLOR_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vs_in,
   input  logic                  hs_in,
   input  logic                  de_in,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_rd_en,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic                  vs_out,
   output logic                  hs_out,
   output logic                  de_out,
   output logic [DATA_WIDTH-1:0] rgb_out
);

   localparam int LAT       = lat(RD_LATENCY);
   // The output register provides the final stage of the timing delay
   localparam int DLY_DEPTH = LAT - 1;

   localparam int unsigned X_LO = H_OFFSET;
   localparam int unsigned X_HI = H_OFFSET + IMG_W;
   localparam int unsigned Y_LO = V_OFFSET;
   localparam int unsigned Y_HI = V_OFFSET + IMG_H;

   generate
      if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_WIDTH)) begin : g_bad_img_size
         $error("img_rom_reader: IMG_W*IMG_H exceeds the ROM address space");
      end
      if (RD_LATENCY < 1) begin : g_bad_latency
         $error("img_rom_reader: RD_LATENCY must be at least 1");
      end
   endgenerate

   state_e                state_q, state_d;
   logic                  vs_q, de_q;
   logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]    x_cur, y_cur;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  rom_rd_en_q, rom_rd_en_d;
   logic                  vs_rise, de_fall, in_win;
   logic [3:0]            dly_tap;
   logic                  vs_out_q, hs_out_q, de_out_q;
   logic [DATA_WIDTH-1:0] rgb_out_q;

   assign vs_rise = vs_in & ~vs_q;
   assign de_fall = ~de_in & de_q;

   // A vs rising edge clears the coordinates for the pixel on the same clock
   assign x_cur = vs_rise ? '0 : x_q;
   assign y_cur = vs_rise ? '0 : y_q;

   // The vs edge that locks the frame already counts as ACTIVE for its pixel
   assign in_win = ((state_q == ACTIVE) | vs_rise) & de_in
                 & (32'(x_cur) >= X_LO) & (32'(x_cur) < X_HI)
                 & (32'(y_cur) >= Y_LO) & (32'(y_cur) < Y_HI);

   // First fetch after a vs edge starts at address zero
   assign fetch_addr = vs_rise ? '0 : next_addr_q;

   // Frame lock: leave WAIT_VS on the first vs edge, only reset returns
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_VS: if (vs_rise) state_d = ACTIVE;
         ACTIVE:  state_d = ACTIVE;
         default: state_d = WAIT_VS;
      endcase
   end

   // Pixel/line counters and ROM fetch address generation
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      rom_addr_d  = rom_addr_q;
      next_addr_d = next_addr_q;
      rom_rd_en_d = in_win;

      if (de_in) begin
         x_d = x_cur + 1'b1;
         y_d = y_cur;
      end else if (de_fall && !vs_rise) begin
         x_d = '0;
         y_d = (y_q == '1) ? y_q : y_q + 1'b1;
      end else begin
         x_d = x_cur;
         y_d = y_cur;
      end

      if (vs_rise) begin
         rom_addr_d  = '0;
         next_addr_d = '0;
      end
      if (in_win) begin
         rom_addr_d  = fetch_addr;
         next_addr_d = fetch_addr + 1'b1;
      end
   end

   // Stage 1 registers: FSM, edge detectors, counters and ROM request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WAIT_VS;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         rom_addr_q  <= '0;
         next_addr_q <= '0;
         rom_rd_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs_in;
         de_q        <= de_in;
         x_q         <= x_d;
         y_q         <= y_d;
         rom_addr_q  <= rom_addr_d;
         next_addr_q <= next_addr_d;
         rom_rd_en_q <= rom_rd_en_d;
      end
   end

   // Timing and window flag ride alongside the ROM access
   sig_delay #(
      .WIDTH (4),
      .DEPTH (DLY_DEPTH)
   ) u_timing_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({vs_in, hs_in, de_in, in_win}),
      .q_o   (dly_tap)
   );

   // Output stage: pick ROM data or background, register with timing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_out_q  <= 1'b0;
         hs_out_q  <= 1'b0;
         de_out_q  <= 1'b0;
         rgb_out_q <= '0;
      end else begin
         vs_out_q  <= dly_tap[3];
         hs_out_q  <= dly_tap[2];
         de_out_q  <= dly_tap[1];
         rgb_out_q <= dly_tap[0] ? rom_rd_data : BG_COLOR;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign rom_rd_en = rom_rd_en_q;
   assign vs_out    = vs_out_q;
   assign hs_out    = hs_out_q;
   assign de_out    = de_out_q;
   assign rgb_out   = rgb_out_q;

endmodule
`default_nettype wire

// File: tb/tb_img_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_rom_reader
// Description : Directed bench for img_rom_reader. Three instances share one
//               stimulus: A (window at 2,1; RD_LATENCY=1), B (window at 0,0),
//               C (window at 2,1; RD_LATENCY=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_rom_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vs_in, hs_in, de_in;

   logic [15:0] rom_addr_a, rom_addr_b, rom_addr_c;
   logic        rom_rd_en_a, rom_rd_en_b, rom_rd_en_c;
   logic [23:0] rom_a_q, rom_b_q, rom_c1_q, rom_c2_q;
   logic        vs_out_a, hs_out_a, de_out_a;
   logic        vs_out_b, hs_out_b, de_out_b;
   logic        vs_out_c, hs_out_c, de_out_c;
   logic [23:0] rgb_out_a, rgb_out_b, rgb_out_c;

   int          n_vec = 0;
   int          n_mis = 0;
   logic        lk;
   logic        prev_vs;
   int          last_a, last_b;
   logic        h_vs [4];
   logic        h_hs [4];
   logic        h_de [4];
   logic [23:0] h_ra [4];
   logic [23:0] h_rb [4];

   initial forever #5 clk = ~clk;

   img_rom_reader #(
      .ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2),
      .H_OFFSET(2), .V_OFFSET(1), .RD_LATENCY(1), .BG_COLOR(24'h000000)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rom_addr(rom_addr_a), .rom_rd_en(rom_rd_en_a), .rom_rd_data(rom_a_q),
      .vs_out(vs_out_a), .hs_out(hs_out_a), .de_out(de_out_a), .rgb_out(rgb_out_a)
   );

   img_rom_reader #(
      .ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2),
      .H_OFFSET(0), .V_OFFSET(0), .RD_LATENCY(1), .BG_COLOR(24'h000000)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rom_addr(rom_addr_b), .rom_rd_en(rom_rd_en_b), .rom_rd_data(rom_b_q),
      .vs_out(vs_out_b), .hs_out(hs_out_b), .de_out(de_out_b), .rgb_out(rgb_out_b)
   );

   img_rom_reader #(
      .ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2),
      .H_OFFSET(2), .V_OFFSET(1), .RD_LATENCY(2), .BG_COLOR(24'h000000)
   ) dut_c (
      .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rom_addr(rom_addr_c), .rom_rd_en(rom_rd_en_c), .rom_rd_data(rom_c2_q),
      .vs_out(vs_out_c), .hs_out(hs_out_c), .de_out(de_out_c), .rgb_out(rgb_out_c)
   );

   // ROM models: data = {A5, address}
   always @(posedge clk) begin
      rom_a_q  <= {8'hA5, rom_addr_a};
      rom_b_q  <= {8'hA5, rom_addr_b};
      rom_c1_q <= {8'hA5, rom_addr_c};
      rom_c2_q <= rom_c1_q;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_hist();
      for (int i = 0; i < 4; i++) begin
         h_vs[i] = 1'b0; h_hs[i] = 1'b0; h_de[i] = 1'b0;
         h_ra[i] = 24'h0; h_rb[i] = 24'h0;
      end
   endtask

   // One clock of stimulus; l/c are the line/column of an active pixel
   // (-1 when not a pixel). Expected outputs come from the picture geometry.
   task automatic tick(input logic v, input logic h, input logic d,
                       input int l, input int c);
      logic wa, wb;
      int   aa, ab;
      vs_in = v; hs_in = h; de_in = d;
      if (rst_n && v && !prev_vs) begin
         lk = 1'b1; last_a = 0; last_b = 0;
      end
      prev_vs = rst_n ? v : 1'b0;
      wa = rst_n && lk && d && l >= 1 && l <= 2 && c >= 2 && c <= 5;
      wb = rst_n && lk && d && l >= 0 && l <= 1 && c >= 0 && c <= 3;
      aa = (l - 1) * 4 + (c - 2);
      ab = l * 4 + c;
      if (wa) last_a = aa;
      if (wb) last_b = ab;
      for (int i = 3; i > 0; i--) begin
         h_vs[i] = h_vs[i-1]; h_hs[i] = h_hs[i-1]; h_de[i] = h_de[i-1];
         h_ra[i] = h_ra[i-1]; h_rb[i] = h_rb[i-1];
      end
      h_vs[0] = rst_n & v;
      h_hs[0] = rst_n & h;
      h_de[0] = rst_n & d;
      h_ra[0] = wa ? {8'hA5, 16'(aa)} : 24'h000000;
      h_rb[0] = wb ? {8'hA5, 16'(ab)} : 24'h000000;
      @(posedge clk);
      #1;
      chk("a.rd_en", 32'(rom_rd_en_a), 32'(wa));
      chk("a.addr",  32'(rom_addr_a),  32'(last_a));
      chk("a.vs",    32'(vs_out_a),    32'(h_vs[2]));
      chk("a.hs",    32'(hs_out_a),    32'(h_hs[2]));
      chk("a.de",    32'(de_out_a),    32'(h_de[2]));
      chk("a.rgb",   32'(rgb_out_a),   32'(h_ra[2]));
      chk("b.rd_en", 32'(rom_rd_en_b), 32'(wb));
      chk("b.addr",  32'(rom_addr_b),  32'(last_b));
      chk("b.vs",    32'(vs_out_b),    32'(h_vs[2]));
      chk("b.hs",    32'(hs_out_b),    32'(h_hs[2]));
      chk("b.de",    32'(de_out_b),    32'(h_de[2]));
      chk("b.rgb",   32'(rgb_out_b),   32'(h_rb[2]));
      chk("c.rd_en", 32'(rom_rd_en_c), 32'(wa));
      chk("c.addr",  32'(rom_addr_c),  32'(last_a));
      chk("c.vs",    32'(vs_out_c),    32'(h_vs[3]));
      chk("c.hs",    32'(hs_out_c),    32'(h_hs[3]));
      chk("c.de",    32'(de_out_c),    32'(h_de[3]));
      chk("c.rgb",   32'(rgb_out_c),   32'(h_ra[3]));
   endtask

   // Assert reset between clock edges and confirm outputs clear at once
   task automatic async_reset();
      #2 rst_n = 1'b0;
      lk = 1'b0; prev_vs = 1'b0; last_a = 0; last_b = 0;
      clear_hist();
      #1;
      chk("rst.a.rgb", 32'(rgb_out_a), 32'h0);
      chk("rst.a.de",  32'(de_out_a),  32'h0);
      chk("rst.a.vs",  32'(vs_out_a),  32'h0);
      chk("rst.a.hs",  32'(hs_out_a),  32'h0);
      chk("rst.a.en",  32'(rom_rd_en_a), 32'h0);
      chk("rst.a.addr", 32'(rom_addr_a), 32'h0);
      chk("rst.b.rgb", 32'(rgb_out_b), 32'h0);
      chk("rst.b.addr", 32'(rom_addr_b), 32'h0);
      chk("rst.c.rgb", 32'(rgb_out_c), 32'h0);
      chk("rst.c.de",  32'(de_out_c),  32'h0);
   endtask

   task automatic release_reset();
      #2 rst_n = 1'b1;
   endtask

   // One line: hsync, back porch, 8 active pixels, front porch
   task automatic drive_line(input int l, input logic vs_first, input int rst_col);
      tick(1'b0, 1'b1, 1'b0, -1, -1);
      tick(1'b0, 1'b1, 1'b0, -1, -1);
      tick(1'b0, 1'b0, 1'b0, -1, -1);
      tick(1'b0, 1'b0, 1'b0, -1, -1);
      for (int c = 0; c < 8; c++) begin
         if (rst_col >= 0 && c == rst_col)     async_reset();
         if (rst_col >= 0 && c == rst_col + 2) release_reset();
         tick(vs_first && c == 0, 1'b0, 1'b1, l, c);
      end
      tick(1'b0, 1'b0, 1'b0, -1, -1);
      tick(1'b0, 1'b0, 1'b0, -1, -1);
   endtask

   // One frame of 4 lines; vs either leads in blanking or lands on pixel (0,0)
   task automatic drive_frame(input logic vs_with_de, input int rst_line, input int rst_col);
      if (!vs_with_de) begin
         for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, -1, -1);
      end
      for (int l = 0; l < 4; l++) begin
         drive_line(l, vs_with_de && l == 0, (l == rst_line) ? rst_col : -1);
      end
   endtask

   initial begin
      rst_n = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
      lk = 1'b0; prev_vs = 1'b0; last_a = 0; last_b = 0;
      clear_hist();

      // Reset state, then release mid-line with de toggling and no vs
      tick(1'b0, 1'b0, 1'b1, -1, -1);
      tick(1'b0, 1'b0, 1'b0, -1, -1);
      release_reset();
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, -1, -1);
      tick(1'b0, 1'b0, 1'b0, -1, -1);
      tick(1'b0, 1'b0, 1'b0, -1, -1);
      drive_line(0, 1'b0, -1);
      drive_line(1, 1'b0, -1);
      drive_line(2, 1'b0, -1);

      // Two locked frames, each restarting at address 0
      drive_frame(1'b0, -1, -1);
      drive_frame(1'b0, -1, -1);

      // vs rising together with the first de pixel
      drive_frame(1'b1, -1, -1);

      // Reset during line 2, then a clean frame afterwards
      drive_frame(1'b0, 2, 3);
      drive_frame(1'b0, -1, -1);

      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
